// File: rtl/alu_ctrl_stage.sv
// ID->EX stage of the 5-stage MIPS core: decodes ALUControl and operands, registers them with
// the writeback/memory/branch controls, and handles stall, flush and illegal-opcode counting.
module alu_ctrl_stage #(
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [31:0]          id_instr,
    input  logic [31:0]          id_rs_data,
    input  logic [31:0]          id_rt_data,
    input  logic                 ex_stall,
    input  logic                 ex_flush,
    output logic                 id_ready,
    output logic                 ex_valid,
    output logic [3:0]           ex_alu_ctrl,
    output logic [31:0]          ex_ain,
    output logic [31:0]          ex_bin,
    output logic [4:0]           ex_wr_addr,
    output logic                 ex_reg_write,
    output logic                 ex_mem_read,
    output logic                 ex_mem_write,
    output logic                 ex_branch,
    output logic                 ex_illegal,
    output logic [ILL_CNT_W-1:0] ill_count
);

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_XOR = 4'b0011,
        ALU_SLL = 4'b0100,
        ALU_SRL = 4'b0101,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_SRA = 4'b1000,
        ALU_BEQ = 4'b1001,
        ALU_BNE = 4'b1010,
        ALU_NOR = 4'b1100
    } alu_ctrl_e;

    // Instruction fields
    logic [5:0]  opcode;
    logic [4:0]  rsField;
    logic [4:0]  rtField;
    logic [4:0]  rdField;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [31:0] immSext;
    logic [31:0] immZext;

    assign opcode  = id_instr[31:26];
    assign rsField = id_instr[25:21];
    assign rtField = id_instr[20:16];
    assign rdField = id_instr[15:11];
    assign shamt   = id_instr[10:6];
    assign funct   = id_instr[5:0];
    assign imm     = id_instr[15:0];
    assign immSext = {{16{imm[15]}}, imm};
    assign immZext = {16'h0000, imm};

    // Decoded (unregistered) view of the instruction currently in ID
    logic [3:0]  decAluCtrl;
    logic [31:0] decAin;
    logic [31:0] decBin;
    logic [4:0]  decWrAddr;
    logic        decRegWrite;
    logic        decMemRead;
    logic        decMemWrite;
    logic        decBranch;
    logic        decIllegal;

    // Illegal encodings fall through to the bubble values set as defaults here.
    always_comb begin
        decAluCtrl  = ALU_ADD;
        decAin      = 32'h0;
        decBin      = 32'h0;
        decWrAddr   = 5'd0;
        decRegWrite = 1'b0;
        decMemRead  = 1'b0;
        decMemWrite = 1'b0;
        decBranch   = 1'b0;
        decIllegal  = 1'b0;
        unique case (opcode)
            6'h00: begin
                decWrAddr   = rdField;
                decRegWrite = 1'b1;
                decAin      = id_rs_data;
                decBin      = id_rt_data;
                unique case (funct)
                    6'h20, 6'h21: decAluCtrl = ALU_ADD;
                    6'h22, 6'h23: decAluCtrl = ALU_SUB;
                    6'h24:        decAluCtrl = ALU_AND;
                    6'h25:        decAluCtrl = ALU_OR;
                    6'h26:        decAluCtrl = ALU_XOR;
                    6'h27:        decAluCtrl = ALU_NOR;
                    6'h2A:        decAluCtrl = ALU_SLT;
                    6'h00: begin
                        decAluCtrl = ALU_SLL;
                        decAin     = {27'h0, shamt};
                    end
                    6'h02: begin
                        decAluCtrl = ALU_SRL;
                        decAin     = {27'h0, shamt};
                    end
                    6'h03: begin
                        decAluCtrl = ALU_SRA;
                        decAin     = {27'h0, shamt};
                    end
                    6'h04: begin
                        decAluCtrl = ALU_SLL;
                        decAin     = {27'h0, id_rs_data[4:0]};
                    end
                    6'h06: begin
                        decAluCtrl = ALU_SRL;
                        decAin     = {27'h0, id_rs_data[4:0]};
                    end
                    6'h07: begin
                        decAluCtrl = ALU_SRA;
                        decAin     = {27'h0, id_rs_data[4:0]};
                    end
                    default: begin
                        decIllegal  = 1'b1;
                        decWrAddr   = 5'd0;
                        decRegWrite = 1'b0;
                        decAin      = 32'h0;
                        decBin      = 32'h0;
                    end
                endcase
            end
            6'h08, 6'h09: begin
                decAluCtrl  = ALU_ADD;
                decAin      = id_rs_data;
                decBin      = immSext;
                decWrAddr   = rtField;
                decRegWrite = 1'b1;
            end
            6'h23: begin
                decAluCtrl  = ALU_ADD;
                decAin      = id_rs_data;
                decBin      = immSext;
                decWrAddr   = rtField;
                decRegWrite = 1'b1;
                decMemRead  = 1'b1;
            end
            6'h2B: begin
                decAluCtrl  = ALU_ADD;
                decAin      = id_rs_data;
                decBin      = immSext;
                decWrAddr   = rtField;
                decMemWrite = 1'b1;
            end
            6'h0A: begin
                decAluCtrl  = ALU_SLT;
                decAin      = id_rs_data;
                decBin      = immSext;
                decWrAddr   = rtField;
                decRegWrite = 1'b1;
            end
            6'h0C: begin
                decAluCtrl  = ALU_AND;
                decAin      = id_rs_data;
                decBin      = immZext;
                decWrAddr   = rtField;
                decRegWrite = 1'b1;
            end
            6'h0D: begin
                decAluCtrl  = ALU_OR;
                decAin      = id_rs_data;
                decBin      = immZext;
                decWrAddr   = rtField;
                decRegWrite = 1'b1;
            end
            6'h0E: begin
                decAluCtrl  = ALU_XOR;
                decAin      = id_rs_data;
                decBin      = immZext;
                decWrAddr   = rtField;
                decRegWrite = 1'b1;
            end
            // lui is executed as imm << 16 on the shifter
            6'h0F: begin
                decAluCtrl  = ALU_SLL;
                decAin      = 32'd16;
                decBin      = immZext;
                decWrAddr   = rtField;
                decRegWrite = 1'b1;
            end
            6'h04: begin
                decAluCtrl = ALU_BEQ;
                decAin     = id_rs_data;
                decBin     = id_rt_data;
                decWrAddr  = rtField;
                decBranch  = 1'b1;
            end
            6'h05: begin
                decAluCtrl = ALU_BNE;
                decAin     = id_rs_data;
                decBin     = id_rt_data;
                decWrAddr  = rtField;
                decBranch  = 1'b1;
            end
            default: decIllegal = 1'b1;
        endcase
    end

    // ID/EX register state
    logic                 valid_q,    valid_d;
    logic [3:0]           aluCtrl_q,  aluCtrl_d;
    logic [31:0]          ain_q,      ain_d;
    logic [31:0]          bin_q,      bin_d;
    logic [4:0]           wrAddr_q,   wrAddr_d;
    logic                 regWrite_q, regWrite_d;
    logic                 memRead_q,  memRead_d;
    logic                 memWrite_q, memWrite_d;
    logic                 branch_q,   branch_d;
    logic                 illegal_q,  illegal_d;
    logic [ILL_CNT_W-1:0] illCnt_q,   illCnt_d;

    logic loadDecode;
    assign loadDecode = ~ex_flush & ~ex_stall & id_valid;

    // Flush beats stall; a stall holds every register including the counter.
    always_comb begin
        valid_d    = valid_q;
        aluCtrl_d  = aluCtrl_q;
        ain_d      = ain_q;
        bin_d      = bin_q;
        wrAddr_d   = wrAddr_q;
        regWrite_d = regWrite_q;
        memRead_d  = memRead_q;
        memWrite_d = memWrite_q;
        branch_d   = branch_q;
        illegal_d  = illegal_q;
        illCnt_d   = illCnt_q;
        if (ex_flush || (!ex_stall && !id_valid)) begin
            valid_d    = 1'b0;
            aluCtrl_d  = ALU_ADD;
            ain_d      = 32'h0;
            bin_d      = 32'h0;
            wrAddr_d   = 5'd0;
            regWrite_d = 1'b0;
            memRead_d  = 1'b0;
            memWrite_d = 1'b0;
            branch_d   = 1'b0;
            illegal_d  = 1'b0;
        end else if (loadDecode) begin
            valid_d    = 1'b1;
            aluCtrl_d  = decAluCtrl;
            ain_d      = decAin;
            bin_d      = decBin;
            wrAddr_d   = decWrAddr;
            regWrite_d = decRegWrite;
            memRead_d  = decMemRead;
            memWrite_d = decMemWrite;
            branch_d   = decBranch;
            illegal_d  = decIllegal;
            if (decIllegal && (illCnt_q != {ILL_CNT_W{1'b1}})) begin
                illCnt_d = illCnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            aluCtrl_q  <= ALU_ADD;
            ain_q      <= 32'h0;
            bin_q      <= 32'h0;
            wrAddr_q   <= 5'd0;
            regWrite_q <= 1'b0;
            memRead_q  <= 1'b0;
            memWrite_q <= 1'b0;
            branch_q   <= 1'b0;
            illegal_q  <= 1'b0;
            illCnt_q   <= '0;
        end else begin
            valid_q    <= valid_d;
            aluCtrl_q  <= aluCtrl_d;
            ain_q      <= ain_d;
            bin_q      <= bin_d;
            wrAddr_q   <= wrAddr_d;
            regWrite_q <= regWrite_d;
            memRead_q  <= memRead_d;
            memWrite_q <= memWrite_d;
            branch_q   <= branch_d;
            illegal_q  <= illegal_d;
            illCnt_q   <= illCnt_d;
        end
    end

    assign id_ready     = ~ex_stall;
    assign ex_valid     = valid_q;
    assign ex_alu_ctrl  = aluCtrl_q;
    assign ex_ain       = ain_q;
    assign ex_bin       = bin_q;
    assign ex_wr_addr   = wrAddr_q;
    assign ex_reg_write = regWrite_q;
    assign ex_mem_read  = memRead_q;
    assign ex_mem_write = memWrite_q;
    assign ex_branch    = branch_q;
    assign ex_illegal   = illegal_q;
    assign ill_count    = illCnt_q;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed, table-driven bench for alu_ctrl_stage with hand-computed expectations.
module tb_alu_ctrl_stage;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic        ex_stall;
    logic        ex_flush;
    logic        id_ready;
    logic        ex_valid;
    logic [3:0]  ex_alu_ctrl;
    logic [31:0] ex_ain;
    logic [31:0] ex_bin;
    logic [4:0]  ex_wr_addr;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_branch;
    logic        ex_illegal;
    logic [7:0]  ill_count;

    int checks = 0;
    int failures = 0;

    alu_ctrl_stage #(.ILL_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .ex_stall(ex_stall),
        .ex_flush(ex_flush), .id_ready(id_ready), .ex_valid(ex_valid),
        .ex_alu_ctrl(ex_alu_ctrl), .ex_ain(ex_ain), .ex_bin(ex_bin),
        .ex_wr_addr(ex_wr_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_illegal(ex_illegal),
        .ill_count(ill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        ev;
        logic [3:0]  alu;
        logic [31:0] ain;
        logic [31:0] bin;
        logic [4:0]  wr;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input vec_t e);
        checkVal({tag, " ex_valid"},     {31'h0, ex_valid},     {31'h0, e.ev});
        checkVal({tag, " ex_alu_ctrl"},  {28'h0, ex_alu_ctrl},  {28'h0, e.alu});
        checkVal({tag, " ex_ain"},       ex_ain,                e.ain);
        checkVal({tag, " ex_bin"},       ex_bin,                e.bin);
        checkVal({tag, " ex_wr_addr"},   {27'h0, ex_wr_addr},   {27'h0, e.wr});
        checkVal({tag, " ex_reg_write"}, {31'h0, ex_reg_write}, {31'h0, e.rw});
        checkVal({tag, " ex_mem_read"},  {31'h0, ex_mem_read},  {31'h0, e.mr});
        checkVal({tag, " ex_mem_write"}, {31'h0, ex_mem_write}, {31'h0, e.mw});
        checkVal({tag, " ex_branch"},    {31'h0, ex_branch},    {31'h0, e.br});
        checkVal({tag, " ex_illegal"},   {31'h0, ex_illegal},   {31'h0, e.ill});
    endtask

    function automatic vec_t mk(input logic v, input logic [31:0] instr, input logic [31:0] rs,
                                input logic [31:0] rt, input logic ev, input logic [3:0] alu,
                                input logic [31:0] ain, input logic [31:0] bin, input logic [4:0] wr,
                                input logic rw, input logic mr, input logic mw, input logic br,
                                input logic ill);
        vec_t r;
        r.v = v; r.instr = instr; r.rs = rs; r.rt = rt; r.ev = ev; r.alu = alu;
        r.ain = ain; r.bin = bin; r.wr = wr; r.rw = rw; r.mr = mr; r.mw = mw;
        r.br = br; r.ill = ill;
        return r;
    endfunction

    // Drive ID on the falling edge, then sample 1 time unit after the rising edge.
    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] rs,
                                 input logic [31:0] rt, input logic stall, input logic flush);
        @(negedge clk);
        id_valid   = v;
        id_instr   = instr;
        id_rs_data = rs;
        id_rt_data = rt;
        ex_stall   = stall;
        ex_flush   = flush;
        @(posedge clk);
        #1;
    endtask

    vec_t bubble;
    vec_t beqExp;
    vec_t illExp;
    int   expCnt;

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_instr = 32'h0; id_rs_data = 32'h0;
        id_rt_data = 32'h0; ex_stall = 1'b0; ex_flush = 1'b0;
        bubble = mk(0, 0, 0, 0, 0, 4'b0010, 0, 0, 0, 0, 0, 0, 0, 0);
        expCnt = 0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", bubble);
        checkVal("reset ill_count", {24'h0, ill_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        //          v  instr         rs           rt           ev alu     ain          bin          wr rw mr mw br ill
        vecs.push_back(mk(1, 32'h00221820, 32'd5,       32'hFFFFFFF9, 1, 4'b0010, 32'd5,       32'hFFFFFFF9, 3, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h000520C3, 32'h1234,    32'h80000000, 1, 4'b1000, 32'd3,       32'h80000000, 4, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h00252007, 32'h23,      32'h80000000, 1, 4'b1000, 32'd3,       32'h80000000, 4, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h34228001, 32'h10,      32'h0,        1, 4'b0001, 32'h10,      32'h00008001, 2, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h20228001, 32'h10,      32'h0,        1, 4'b0010, 32'h10,      32'hFFFF8001, 2, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h3C031234, 32'hDEAD,    32'h0,        1, 4'b0100, 32'd16,      32'h00001234, 3, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h8C260004, 32'h100,     32'h0,        1, 4'b0010, 32'h100,     32'h4,        6, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 32'hAC26FFFC, 32'h100,     32'h77,       1, 4'b0010, 32'h100,     32'hFFFFFFFC, 6, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 32'h00223822, 32'd9,       32'd4,        1, 4'b0110, 32'd9,       32'd4,        7, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h2822FFFF, 32'd3,       32'h0,        1, 4'b0111, 32'd3,       32'hFFFFFFFF, 2, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h14220010, 32'd1,       32'd2,        1, 4'b1010, 32'd1,       32'd2,        2, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 32'h00221827, 32'hF0,      32'h0F,       1, 4'b1100, 32'hF0,      32'h0F,       3, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h00000000, 32'h5,       32'hABCD,     1, 4'b0100, 32'h0,       32'hABCD,     0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h00221801, 32'h5,       32'h6,        1, 4'b0010, 32'h0,       32'h0,        0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 32'h00221820, 32'h5,       32'h6,        0, 4'b0010, 32'h0,       32'h0,        0, 0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].v, vecs[i].instr, vecs[i].rs, vecs[i].rt, 1'b0, 1'b0);
            checkOutput($sformatf("vec%0d", i), vecs[i]);
            if (vecs[i].v && vecs[i].ill) expCnt++;
        end
        checkVal("table ill_count", {24'h0, ill_count}, expCnt);

        // beq loaded, then a stall holds it while a different instruction waits in ID
        beqExp = mk(1, 32'h10220005, 9, 9, 1, 4'b1001, 9, 9, 2, 0, 0, 0, 1, 0);
        applyStimulus(1, 32'h10220005, 9, 9, 1'b0, 1'b0);
        checkOutput("beq load", beqExp);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 32'h00221820, 32'd77, 32'd88, 1'b1, 1'b0);
            checkOutput($sformatf("beq stall%0d", i), beqExp);
            checkVal("id_ready stalled", {31'h0, id_ready}, 32'd0);
        end
        applyStimulus(1, 32'h00221820, 32'd77, 32'd88, 1'b1, 1'b1);
        checkOutput("stall+flush", bubble);
        checkVal("id_ready free", {31'h0, id_ready}, 32'd0);

        // Illegal opcode: stall and flush must not bump the counter
        illExp = mk(1, 32'hFC000000, 0, 0, 1, 4'b0010, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 32'hFC000000, 32'h55, 32'h66, 1'b0, 1'b0);
        expCnt++;
        checkOutput("ill load", illExp);
        checkVal("ill count load", {24'h0, ill_count}, expCnt);
        applyStimulus(1, 32'hFC000000, 32'h55, 32'h66, 1'b1, 1'b0);
        checkVal("ill count stall", {24'h0, ill_count}, expCnt);
        checkOutput("ill stall", illExp);
        applyStimulus(1, 32'hFC000000, 32'h55, 32'h66, 1'b0, 1'b1);
        checkVal("ill count flush", {24'h0, ill_count}, expCnt);
        checkOutput("ill flush", bubble);

        for (int i = 0; i < 300; i++) begin
            applyStimulus(1, 32'hFC000000, 32'h55, 32'h66, 1'b0, 1'b0);
            if (expCnt < 255) expCnt++;
            if (i == 100 || i == 299) checkOutput($sformatf("ill run%0d", i), illExp);
        end
        checkVal("ill count saturated", {24'h0, ill_count}, 32'd255);

        // Async reset asserted between edges clears state at once
        applyStimulus(1, 32'h00221820, 32'd5, 32'd6, 1'b0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("mid reset", bubble);
        checkVal("mid reset ill_count", {24'h0, ill_count}, 32'd0);
        ex_stall = 1'b1;
        #1;
        checkVal("id_ready in reset", {31'h0, id_ready}, 32'd0);
        ex_stall = 1'b0;
        #1;
        checkVal("id_ready in reset free", {31'h0, id_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1, 32'h00221820, 32'd5, 32'hFFFFFFF9, 1'b0, 1'b0);
        checkOutput("post reset", vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
